ps2_key_fifo: RTL and testbench
===============================

# ps2_key_fifo

Parametrised PS/2 keyboard front end, successor to the receive/validate/translate chain. It deglitches `ps2c`, receives 11-bit frames and checks start, odd parity and stop bits. It tracks the `E0` (extended) and `F0` (break) prefixes, translates scan code set 2 make codes to 7-bit ASCII, and queues results in a FIFO read by the consumer. It also raises the one-cycle `iniciar`/`terminar` command strobes used by the control FSM.

## Interface
- `FIFO_DEPTH`, 8: entries in output FIFO; power of two, 2..64.
- `FILTER_LEN`, 8: consecutive equal `clk` samples needed to accept a `ps2c` level change.
- `TIMEOUT_CYC`, 50000: idle `clk` cycles mid-frame before the frame is aborted.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2d`  in  1  PS/2 data, asynchronous.
- `ps2c`  in  1  PS/2 clock, asynchronous.
- `rx_en`  in  1  receiver enable, sampled only in IDLE.
- `rd_en`  in  1  pop FIFO head; ignored when empty.
- `valido`  out  1  FIFO not empty.
- `traduccion`  out  7  ASCII at FIFO head; 0 when empty.
- `brk`  out  1  head entry is a key release; always 0 without `PS2_BREAK_REPORT_EN`.
- `iniciar`  out  1  one-cycle pulse on Enter make.
- `terminar`  out  1  one-cycle pulse on Esc make.
- `frame_err`  out  1  one-cycle pulse on a bad start/parity/stop bit or a timeout.
- `overflow`  out  1  one-cycle pulse when an entry is dropped because the FIFO is full.

## Operation
- Input conditioning: `ps2c`/`ps2d` pass through 2-flop synchronisers. Filtered `ps2c` changes only after `FILTER_LEN` equal samples. A falling edge of the filtered clock is one `fall` tick that samples synced `ps2d`.
- Receiver FSM: IDLE -> DATA -> PAR -> STOP -> IDLE.
  - IDLE: on `fall` with `rx_en`=1 and `ps2d`=0, go to DATA. If `ps2d`=1, pulse `frame_err` and stay.
  - DATA: shift 8 bits LSB first.
  - PAR: sample the parity bit.
  - STOP: sample the stop bit. If XOR of data and parity is 1 and stop=1, emit `byte_rdy` with the byte. Otherwise pulse `frame_err` and discard the byte.
  - `rx_en` deassertion mid-frame does not abort the frame.
  - Timeout counter is cleared on every `fall` and counts in non-IDLE states. On reaching `TIMEOUT_CYC`, go to IDLE and pulse `frame_err`.
- Decoder (acts on `byte_rdy`):
  - `E0`: set `ext`.
  - `F0`: set `brk_p`.
  - Any other byte is a code. After the code, `ext` and `brk_p` clear.
  - Non-extended map: A..Z -> 0x41..0x5A (e.g. 1C->41, 32->42); 0..9 -> 0x30..0x39 (45->30, 16->31); 29->20; 5A->0D; 76->1B; 66->08.
  - Extended map: E0 5A -> 0D. Other extended codes are dropped silently.
  - Unmapped non-extended codes are dropped silently (no error).
  - A mapped make pushes {brk=0, code}.
  - A mapped break pushes {brk=1, code} only if `PS2_BREAK_REPORT_EN`; otherwise nothing is pushed.
  - `iniciar` pulses on make of 0D; `terminar` pulses on make of 1B. Both pulse even if the FIFO is full.
- FIFO:
  - Head data is combinationally visible.
  - Push when full: the entry is dropped and `overflow` pulses.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pop when empty: no effect.
  - Pointers wrap modulo `FIFO_DEPTH`. An extra pointer bit distinguishes full from empty.
- Reset values: FSM IDLE, FIFO empty, `ext`/`brk_p`=0. All outputs are 0.

## Timing
- Cycle n: `fall` for the stop bit. n+1: `byte_rdy`. n+2: decode, push, and the `iniciar`/`terminar` pulse. n+3: `valido`=1 and head valid.
- `rd_en` at cycle m: the next head, or `valido`=0, appears at m+1.
- Strobes are exactly one `clk` cycle wide.
- Reset asserted mid-frame or with a non-empty FIFO: immediate return to reset values. The partial frame is lost.

## Configuration
- `PS2_BREAK_REPORT_EN` defined: releases of mapped keys are queued with `brk`=1.
- Not defined: releases only clear prefix state. `brk` is tied to 0 and its FIFO storage bit is not built.

## Test plan
- Frame 1C, parity 0, stop 1 -> `traduccion`=0x41, `brk`=0, `valido`=1 at n+3; `rd_en` -> `valido`=0.
- Frame 1C with parity forced to 1 -> `frame_err` pulse, FIFO stays empty. Then a good frame 32 -> 0x42.
- Sequence 5A, F0 5A, 76 -> `iniciar` pulse, then `terminar` pulse. With macro, FIFO holds 0D/0, 0D/1, 1B/0; without it, 0D, 1B.
- `FIFO_DEPTH`+1 makes of 45 with no reads -> 8 entries of 0x30 and one `overflow` pulse. Push and pop together while full -> no overflow.
- Stop `ps2c` after 4 data bits for `TIMEOUT_CYC` cycles -> `frame_err` and IDLE; the next full frame 16 -> 0x31.
- Glitch on `ps2c` shorter than `FILTER_LEN` cycles -> no bit sampled. Reset pulse mid-frame -> all outputs 0 and FIFO empty.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// ps2_key_fifo_if
//   Read-side bundle of the PS/2 key FIFO.
//   rd_en      : consumer pops the head entry (ignored when empty)
//   valido     : FIFO not empty
//   traduccion : 7-bit ASCII at the FIFO head, 0 when empty
//   brk        : head entry is a key release
//   modport master : the key FIFO (drives the head, receives rd_en)
//   modport slave  : the consumer
interface ps2_key_fifo_if;
    logic       rd_en;
    logic       valido;
    logic [6:0] traduccion;
    logic       brk;

    modport master (input rd_en, output valido, traduccion, brk);
    modport slave  (output rd_en, input valido, traduccion, brk);
endinterface

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//   PS/2 keyboard front end: synchronises and deglitches ps2c, receives
//   11-bit frames (start/odd parity/stop checked), tracks E0/F0 prefixes,
//   translates scan code set 2 make codes to ASCII and queues them.
//   Optional feature macro: PS2_BREAK_REPORT_EN (queue releases with brk=1).
// Ports
//   clk, reset      : system clock, asynchronous active-low reset
//   ps2d, ps2c      : PS/2 data/clock (asynchronous)
//   rx_en           : receiver enable, sampled in IDLE only
//   key             : FIFO read side (rd_en, valido, traduccion, brk)
//   iniciar         : one-cycle pulse on Enter make
//   terminar        : one-cycle pulse on Esc make
//   frame_err       : one-cycle pulse on bad start/parity/stop or timeout
//   overflow        : one-cycle pulse when a full FIFO drops an entry
module ps2_key_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ps2d,
    input  logic           ps2c,
    input  logic           rx_en,
    ps2_key_fifo_if.master key,
    output logic           iniciar,
    output logic           terminar,
    output logic           frame_err,
    output logic           overflow
);
    localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef PS2_BREAK_REPORT_EN
    localparam int unsigned EW = 8;
`else
    localparam int unsigned EW = 7;
`endif

    // ---------------- input conditioning ----------------
    logic [1:0]    c_sync, d_sync;
    logic          filt, fall;
    logic [FW-1:0] fcnt;
    logic          din;

    assign din = d_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync <= '1;
            d_sync <= '1;
            filt   <= 1'b1;
            fcnt   <= '0;
            fall   <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            fall   <= 1'b0;
            // fcnt counts consecutive samples that differ from the filtered level
            if (c_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= c_sync[1];
                fcnt <= '0;
                fall <= filt;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // ---------------- receiver FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} rx_state_t;

    rx_state_t     state, state_n;
    logic [7:0]    sr, sr_n;
    logic [2:0]    bcnt, bcnt_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          rdy_n, err_n, byte_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sr        <= '0;
            bcnt      <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bcnt      <= bcnt_n;
            par       <= par_n;
            tcnt      <= tcnt_n;
            byte_rdy  <= rdy_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        bcnt_n  = bcnt;
        par_n   = par;
        rdy_n   = 1'b0;
        err_n   = 1'b0;
        tcnt_n  = (fall || state == S_IDLE) ? '0 : tcnt + 1'b1;
        unique case (state)
            S_IDLE: if (fall && rx_en) begin
                if (!din) begin
                    state_n = S_DATA;
                    bcnt_n  = '0;
                end else begin
                    err_n = 1'b1;
                end
            end
            S_DATA: if (fall) begin
                sr_n   = {din, sr[7:1]};
                bcnt_n = bcnt + 1'b1;
                if (bcnt == 3'd7) state_n = S_PAR;
            end
            S_PAR: if (fall) begin
                par_n   = din;
                state_n = S_STOP;
            end
            S_STOP: if (fall) begin
                state_n = S_IDLE;
                if ((^sr ^ par) && din) rdy_n = 1'b1;
                else                    err_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (state != S_IDLE && !fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_n = S_IDLE;
            tcnt_n  = '0;
            err_n   = 1'b1;
        end
    end

    // ---------------- decoder ----------------
    // Returns {hit, ascii}; hit=0 for unmapped codes.
    function automatic logic [7:0] map_set2(input logic [7:0] sc);
        logic [6:0] a;
        logic       hit;
        hit = 1'b1;
        unique case (sc)
            8'h1C: a = 7'h41; 8'h32: a = 7'h42; 8'h21: a = 7'h43; 8'h23: a = 7'h44;
            8'h24: a = 7'h45; 8'h2B: a = 7'h46; 8'h34: a = 7'h47; 8'h33: a = 7'h48;
            8'h43: a = 7'h49; 8'h3B: a = 7'h4A; 8'h42: a = 7'h4B; 8'h4B: a = 7'h4C;
            8'h3A: a = 7'h4D; 8'h31: a = 7'h4E; 8'h44: a = 7'h4F; 8'h4D: a = 7'h50;
            8'h15: a = 7'h51; 8'h2D: a = 7'h52; 8'h1B: a = 7'h53; 8'h2C: a = 7'h54;
            8'h3C: a = 7'h55; 8'h2A: a = 7'h56; 8'h1D: a = 7'h57; 8'h22: a = 7'h58;
            8'h35: a = 7'h59; 8'h1A: a = 7'h5A;
            8'h45: a = 7'h30; 8'h16: a = 7'h31; 8'h1E: a = 7'h32; 8'h26: a = 7'h33;
            8'h25: a = 7'h34; 8'h2E: a = 7'h35; 8'h36: a = 7'h36; 8'h3D: a = 7'h37;
            8'h3E: a = 7'h38; 8'h46: a = 7'h39;
            8'h29: a = 7'h20; 8'h5A: a = 7'h0D; 8'h76: a = 7'h1B; 8'h66: a = 7'h08;
            default: begin a = 7'h00; hit = 1'b0; end
        endcase
        return {hit, a};
    endfunction

    logic       ext, brk_p;
    logic [7:0] lookup;
    logic       push;
    logic [6:0] push_code;
`ifdef PS2_BREAK_REPORT_EN
    logic       push_brk;
`endif

    always_comb begin
        lookup = '0;
        if (ext) begin
            if (sr == 8'h5A) lookup = {1'b1, 7'h0D};
        end else begin
            lookup = map_set2(sr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext       <= 1'b0;
            brk_p     <= 1'b0;
            push      <= 1'b0;
            push_code <= '0;
            iniciar   <= 1'b0;
            terminar  <= 1'b0;
`ifdef PS2_BREAK_REPORT_EN
            push_brk  <= 1'b0;
`endif
        end else begin
            push     <= 1'b0;
            iniciar  <= 1'b0;
            terminar <= 1'b0;
            if (byte_rdy) begin
                if (sr == 8'hE0) begin
                    ext <= 1'b1;
                end else if (sr == 8'hF0) begin
                    brk_p <= 1'b1;
                end else begin
                    ext   <= 1'b0;
                    brk_p <= 1'b0;
                    if (lookup[7]) begin
                        push_code <= lookup[6:0];
`ifdef PS2_BREAK_REPORT_EN
                        push_brk  <= brk_p;
                        push      <= 1'b1;
`else
                        push      <= !brk_p;
`endif
                        iniciar   <= !brk_p && lookup[6:0] == 7'h0D;
                        terminar  <= !brk_p && lookup[6:0] == 7'h1B;
                    end
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;
    logic          empty, full, pop, wr;
    logic [EW-1:0] head, entry;

`ifdef PS2_BREAK_REPORT_EN
    assign entry = {push_brk, push_code};
`else
    assign entry = push_code;
`endif

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = key.rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr    = push && (!full || pop);
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    assign key.valido     = !empty;
    assign key.traduccion = empty ? '0 : head[6:0];
`ifdef PS2_BREAK_REPORT_EN
    assign key.brk        = !empty && head[EW-1];
`else
    assign key.brk        = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLEN  = 8;
    localparam int unsigned TOUT  = 1000;
    localparam int unsigned HALF  = 20;
`ifdef PS2_BREAK_REPORT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2d = 1'b1;
    logic ps2c = 1'b1;
    logic rx_en = 1'b1;
    logic iniciar, terminar, frame_err, overflow;

    ps2_key_fifo_if key ();

    ps2_key_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2d     (ps2d),
        .ps2c     (ps2c),
        .rx_en    (rx_en),
        .key      (key),
        .iniciar  (iniciar),
        .terminar (terminar),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // strobe monitors: number of cycles each strobe was high
    int n_ini = 0, n_term = 0, n_err = 0, n_ovf = 0;
    always @(negedge clk) begin
        if (iniciar)   n_ini++;
        if (terminar)  n_term++;
        if (frame_err) n_err++;
        if (overflow)  n_ovf++;
    end

    // ---------------- reference model ----------------
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};

    logic [7:0] q [$];  // {brk, ascii}
    bit m_ext = 1'b0, m_brk = 1'b0;
    int exp_ini = 0, exp_term = 0, exp_err = 0, exp_ovf = 0;

    function automatic int ref_ascii(input logic [7:0] sc, input bit ext);
        if (ext) return (sc == 8'h5A) ? 13 : -1;
        for (int i = 0; i < 26; i++) if (letters[i] == sc) return 65 + i;
        for (int i = 0; i < 10; i++) if (digits[i] == sc) return 48 + i;
        case (sc)
            8'h29: return 32;
            8'h5A: return 13;
            8'h76: return 27;
            8'h66: return 8;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] key_code(input int idx);
        if (idx < 26) return letters[idx];
        if (idx < 36) return digits[idx - 26];
        case (idx)
            36: return 8'h29;
            37: return 8'h5A;
            38: return 8'h76;
            default: return 8'h66;
        endcase
    endfunction

    task automatic model_push(input logic [7:0] v);
        if (q.size() == DEPTH) exp_ovf++;
        else q.push_back(v);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int a;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            a = ref_ascii(b, m_ext);
            if (a >= 0) begin
                if (!m_brk) begin
                    if (a == 13) exp_ini++;
                    if (a == 27) exp_term++;
                    model_push(8'(a));
                end else if (BRK_EN) begin
                    model_push(8'(128 + a));
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic ps2_bit(input logic v);
        ps2d = v;
        repeat (HALF / 2) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2d = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] b, input bit bad_par);
        send_frame(b, bad_par, 11);
        repeat (4) @(negedge clk);
        if (bad_par) exp_err++;
        else model_byte(b);
    endtask

    task automatic pop_head();
        key.rd_en = 1'b1;
        @(negedge clk);
        key.rd_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({key.valido, key.traduccion, key.brk, iniciar, terminar, frame_err, overflow} !== 12'h000) begin
            $display("FAIL reset_outputs: got valido=%b trad=%h brk=%b ini=%b term=%b err=%b ovf=%b, want all 0",
                     key.valido, key.traduccion, key.brk, iniciar, terminar, frame_err, overflow);
        end else passed++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] e;
        send_key(8'h1C, 1'b0);
        e = q.pop_front();
        checks++;
        if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || key.brk !== e[7]) begin
            $display("FAIL basic_head: got valido=%b trad=%h brk=%b, want 1 %h %b",
                     key.valido, key.traduccion, key.brk, e[6:0], e[7]);
        end else passed++;
        pop_head();
        checks++;
        if (key.valido !== 1'b0 || key.traduccion !== 7'h00) begin
            $display("FAIL basic_empty: got valido=%b trad=%h, want 0 00", key.valido, key.traduccion);
        end else passed++;
    endtask

    task automatic test_parity();
        logic [7:0] e;
        send_key(8'h1C, 1'b1);
        checks++;
        if (n_err !== exp_err || key.valido !== 1'b0) begin
            $display("FAIL parity_err: got errs=%0d valido=%b, want %0d 0", n_err, key.valido, exp_err);
        end else passed++;
        send_key(8'h32, 1'b0);
        e = q.pop_front();
        checks++;
        if (key.valido !== 1'b1 || key.traduccion !== e[6:0]) begin
            $display("FAIL parity_recover: got valido=%b trad=%h, want 1 %h", key.valido, key.traduccion, e[6:0]);
        end else passed++;
        pop_head();
    endtask

    task automatic test_commands();
        logic [7:0] e;
        send_key(8'h5A, 1'b0);
        send_key(8'hF0, 1'b0);
        send_key(8'h5A, 1'b0);
        send_key(8'h76, 1'b0);
        checks++;
        if (n_ini !== exp_ini || n_term !== exp_term) begin
            $display("FAIL cmd_strobes: got ini=%0d term=%0d, want %0d %0d", n_ini, n_term, exp_ini, exp_term);
        end else passed++;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || key.brk !== e[7]) begin
                $display("FAIL cmd_entry: got valido=%b trad=%h brk=%b, want 1 %h %b",
                         key.valido, key.traduccion, key.brk, e[6:0], e[7]);
            end else passed++;
            pop_head();
        end
        checks++;
        if (key.valido !== 1'b0) $display("FAIL cmd_empty: got valido=%b, want 0", key.valido);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        bit seen;
        for (int i = 0; i < DEPTH + 1; i++) send_key(8'h45, 1'b0);
        checks++;
        if (n_ovf !== exp_ovf) $display("FAIL overflow_pulse: got %0d, want %0d", n_ovf, exp_ovf);
        else passed++;
        // push of Enter coincides with its iniciar pulse: pop in that same cycle
        seen = 1'b0;
        fork
            send_frame(8'h5A, 1'b0, 11);
            begin
                for (int i = 0; i < 2000 && !seen; i++) begin
                    @(negedge clk);
                    if (iniciar) begin
                        key.rd_en = 1'b1;
                        seen = 1'b1;
                        @(negedge clk);
                        key.rd_en = 1'b0;
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        void'(q.pop_front());
        model_byte(8'h5A);
        checks++;
        if (!seen) $display("FAIL pushpop_strobe: got no iniciar pulse, want one");
        else passed++;
        checks++;
        if (n_ovf !== exp_ovf) $display("FAIL pushpop_no_ovf: got %0d, want %0d", n_ovf, exp_ovf);
        else passed++;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (key.valido !== 1'b1 || key.traduccion !== e[6:0]) begin
                $display("FAIL ovf_entry: got valido=%b trad=%h, want 1 %h", key.valido, key.traduccion, e[6:0]);
            end else passed++;
            pop_head();
        end
        checks++;
        if (key.valido !== 1'b0) $display("FAIL ovf_empty: got valido=%b, want 0", key.valido);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        send_frame(8'h3C, 1'b0, 5);
        repeat (TOUT + 100) @(negedge clk);
        exp_err++;
        checks++;
        if (n_err !== exp_err || key.valido !== 1'b0) begin
            $display("FAIL timeout_err: got errs=%0d valido=%b, want %0d 0", n_err, key.valido, exp_err);
        end else passed++;
        send_key(8'h16, 1'b0);
        e = q.pop_front();
        checks++;
        if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || n_err !== exp_err) begin
            $display("FAIL timeout_recover: got valido=%b trad=%h errs=%0d, want 1 %h %0d",
                     key.valido, key.traduccion, n_err, e[6:0], exp_err);
        end else passed++;
        pop_head();
    endtask

    task automatic test_glitch();
        logic [7:0] e;
        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (FLEN - 3) @(negedge clk);
        ps2c = 1'b1;
        repeat (5) @(negedge clk);
        ps2d = 1'b1;
        repeat (20) @(negedge clk);
        send_key(8'h1C, 1'b0);
        e = q.pop_front();
        checks++;
        if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || n_err !== exp_err) begin
            $display("FAIL glitch: got valido=%b trad=%h errs=%0d, want 1 %h %0d",
                     key.valido, key.traduccion, n_err, e[6:0], exp_err);
        end else passed++;
        pop_head();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        send_key(8'h1C, 1'b0);
        send_frame(8'h32, 1'b0, 6);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({key.valido, key.traduccion, key.brk, iniciar, terminar, frame_err, overflow} !== 12'h000) begin
            $display("FAIL reset_mid: got valido=%b trad=%h brk=%b ini=%b term=%b err=%b ovf=%b, want all 0",
                     key.valido, key.traduccion, key.brk, iniciar, terminar, frame_err, overflow);
        end else passed++;
        reset = 1'b1;
        q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (3) @(negedge clk);
        send_key(8'h32, 1'b0);
        e = q.pop_front();
        checks++;
        if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || n_err !== exp_err) begin
            $display("FAIL reset_recover: got valido=%b trad=%h errs=%0d, want 1 %h %0d",
                     key.valido, key.traduccion, n_err, e[6:0], exp_err);
        end else passed++;
        pop_head();
    endtask

    task automatic test_random();
        logic [7:0] b, e;
        int r;
        for (int it = 0; it < 45; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) send_key(8'hF0, 1'b0);
            else if (r < 25) send_key(8'hE0, 1'b0);
            else if (r < 30) send_key(8'($urandom), 1'b1);
            else if (r < 40) begin
                do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
                send_key(b, 1'b0);
            end else send_key(key_code($urandom_range(0, 39)), 1'b0);
            if ($urandom_range(0, 3) == 0 || it == 44) begin
                while (q.size() > 0) begin
                    e = q.pop_front();
                    checks++;
                    if (key.valido !== 1'b1 || key.traduccion !== e[6:0] || key.brk !== e[7]) begin
                        $display("FAIL rand_entry: got valido=%b trad=%h brk=%b, want 1 %h %b",
                                 key.valido, key.traduccion, key.brk, e[6:0], e[7]);
                    end else passed++;
                    pop_head();
                end
                checks++;
                if (key.valido !== 1'b0 || key.traduccion !== 7'h00) begin
                    $display("FAIL rand_empty: got valido=%b trad=%h, want 0 00", key.valido, key.traduccion);
                end else passed++;
            end
        end
        checks++;
        if (n_ini !== exp_ini || n_term !== exp_term || n_err !== exp_err || n_ovf !== exp_ovf) begin
            $display("FAIL rand_strobes: got ini=%0d term=%0d err=%0d ovf=%0d, want %0d %0d %0d %0d",
                     n_ini, n_term, n_err, n_ovf, exp_ini, exp_term, exp_err, exp_ovf);
        end else passed++;
    endtask

    initial begin
        key.rd_en = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_commands();
        test_overflow();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
